// File: rtl/chaos_hyper_core.sv
// Fixed-point 4-D hyperchaotic oscillator integrated by forward Euler.
// One shared signed multiplier computes seven products per iteration, then all states update at once.
module chaos_hyper_core #(
    parameter int               WIDTH  = 32,
    parameter int               FRAC   = 16,
    parameter logic [WIDTH-1:0] COEF_A = 32'h000A0000,
    parameter logic [WIDTH-1:0] COEF_B = 32'h0002AAAB,
    parameter logic [WIDTH-1:0] COEF_C = 32'h001C0000,
    parameter logic [WIDTH-1:0] COEF_R = 32'hFFFF0000,
    parameter logic [WIDTH-1:0] INIT_X = 32'h00010000,
    parameter logic [WIDTH-1:0] INIT_Y = '0,
    parameter logic [WIDTH-1:0] INIT_Z = '0,
    parameter logic [WIDTH-1:0] INIT_W = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             chaos_reset,
    input  logic             chaos_step,
    input  logic [4:0]       chaos_shift,
    input  logic [15:0]      chaos_iters,
    output logic             chaos_done,
    output logic             chaos_busy,
    output logic             chaos_sat,
    output logic [WIDTH-1:0] chaos_x,
    output logic [WIDTH-1:0] chaos_y,
    output logic [WIDTH-1:0] chaos_z,
    output logic [WIDTH-1:0] chaos_w
);

    localparam int PW = 2 * WIDTH;

    typedef logic signed [WIDTH-1:0] word_t;
    typedef logic signed [PW-1:0]    wide_t;
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_UPD, ST_DONE} state_t;

    localparam wide_t MAX_W = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam wide_t MIN_W = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic wide_t sx(input word_t v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    function automatic logic ovf(input wide_t v);
        return (v > MAX_W) || (v < MIN_W);
    endfunction

    function automatic word_t clamp(input wide_t v);
        if (v > MAX_W) return MAX_W[WIDTH-1:0];
        if (v < MIN_W) return MIN_W[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    state_t      state_reg, state_next;
    logic [2:0]  idx_reg, idx_next;
    logic [15:0] iter_reg;
    logic [4:0]  shift_reg;
    logic        sat_reg;
    logic        start;
    word_t       st_reg [4];
    word_t       st_upd [4];
    logic [3:0]  st_ovf;
    word_t       p_reg [7];

    // Datapath for the product currently selected by idx_reg
    wide_t diff_w, prod_full, prod_shr;
    word_t diff_sat, mul_a, mul_b, prod_sat;
    logic  diff_ovf, prod_ovf;

    assign diff_w   = sx(st_reg[1]) - sx(st_reg[0]);
    assign diff_sat = clamp(diff_w);
    assign diff_ovf = ovf(diff_w);

    always_comb begin
        mul_a = COEF_R;
        mul_b = st_reg[3];
        case (idx_reg)
            3'd0: begin mul_a = COEF_A;    mul_b = diff_sat;  end
            3'd1: begin mul_a = COEF_C;    mul_b = st_reg[0]; end
            3'd2: begin mul_a = st_reg[0]; mul_b = st_reg[2]; end
            3'd3: begin mul_a = st_reg[0]; mul_b = st_reg[1]; end
            3'd4: begin mul_a = COEF_B;    mul_b = st_reg[2]; end
            3'd5: begin mul_a = st_reg[1]; mul_b = st_reg[2]; end
            default: ;
        endcase
    end

    assign prod_full = mul_a * mul_b;
    assign prod_shr  = prod_full >>> FRAC;
    assign prod_sat  = clamp(prod_shr);
    assign prod_ovf  = ovf(prod_shr);

    // Derivatives, indexed x,y,z,w to match st_reg
    wide_t d_wide [4];

    always_comb begin
        d_wide[0] = sx(p_reg[0]) + sx(st_reg[3]);
        d_wide[1] = sx(p_reg[1]) - sx(st_reg[1]) - sx(p_reg[2]);
        d_wide[2] = sx(p_reg[3]) - sx(p_reg[4]);
        d_wide[3] = sx(p_reg[6]) - sx(p_reg[5]);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            word_t d_sat, inc;
            wide_t sum;
            assign d_sat      = clamp(d_wide[gi]);
            assign inc        = d_sat >>> shift_reg;
            assign sum        = sx(st_reg[gi]) + sx(inc);
            assign st_upd[gi] = clamp(sum);
            assign st_ovf[gi] = ovf(sum) | ovf(d_wide[gi]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        start      = 1'b0;
        chaos_done = 1'b0;
        chaos_busy = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                chaos_done = (state_reg == ST_DONE);
                if (chaos_step) begin
                    start      = 1'b1;
                    state_next = ST_MUL;
                    idx_next   = 3'd0;
                end
            end
            ST_MUL: begin
                chaos_busy = 1'b1;
                idx_next   = idx_reg + 3'd1;
                if (idx_reg == 3'd6) begin
                    state_next = ST_UPD;
                    idx_next   = 3'd0;
                end
            end
            ST_UPD: begin
                chaos_busy = 1'b1;
                state_next = (iter_reg == 16'd1) ? ST_DONE : ST_MUL;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || chaos_reset) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            iter_reg  <= '0;
            shift_reg <= '0;
            sat_reg   <= 1'b0;
            st_reg[0] <= INIT_X;
            st_reg[1] <= INIT_Y;
            st_reg[2] <= INIT_Z;
            st_reg[3] <= INIT_W;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (start) begin
                shift_reg <= chaos_shift;
                iter_reg  <= (chaos_iters == 16'd0) ? 16'd1 : chaos_iters;
            end
            if (state_reg == ST_MUL) begin
                if (prod_ovf || (idx_reg == 3'd0 && diff_ovf))
                    sat_reg <= 1'b1;
            end
            if (state_reg == ST_UPD) begin
                for (int i = 0; i < 4; i++)
                    st_reg[i] <= st_upd[i];
                iter_reg <= iter_reg - 16'd1;
                if (|st_ovf)
                    sat_reg <= 1'b1;
            end
        end
    end

    // Products are fully rewritten before every update, so they need no reset
    always_ff @(posedge clk_clk) begin
        if (state_reg == ST_MUL)
            p_reg[idx_reg] <= prod_sat;
    end

    assign chaos_sat = sat_reg;
    assign chaos_x   = st_reg[0];
    assign chaos_y   = st_reg[1];
    assign chaos_z   = st_reg[2];
    assign chaos_w   = st_reg[3];

endmodule

// File: tb/tb_chaos_hyper_core.sv
// Directed bench for chaos_hyper_core: hand-derived Euler results, timing, reload and saturation.
module tb_chaos_hyper_core;

    logic        clk = 1'b0;
    logic        rstn;
    logic        creset;
    logic        step, step2;
    logic [4:0]  shift;
    logic [15:0] iters;
    logic        done, busy, sat;
    logic [31:0] x, y, z, w;
    logic        done2, busy2, sat2;
    logic [31:0] x2, y2, z2, w2;

    int total = 0;
    int bad = 0;
    int busy_err = 0;
    int edges;

    always #5 clk = ~clk;

    chaos_hyper_core dut (
        .clk_clk(clk), .reset_reset_n(rstn), .chaos_reset(creset),
        .chaos_step(step), .chaos_shift(shift), .chaos_iters(iters),
        .chaos_done(done), .chaos_busy(busy), .chaos_sat(sat),
        .chaos_x(x), .chaos_y(y), .chaos_z(z), .chaos_w(w)
    );

    chaos_hyper_core #(.INIT_X(32'h7FFF0000), .INIT_Y(32'h7FFF0000)) dut_big (
        .clk_clk(clk), .reset_reset_n(rstn), .chaos_reset(creset),
        .chaos_step(step2), .chaos_shift(shift), .chaos_iters(iters),
        .chaos_done(done2), .chaos_busy(busy2), .chaos_sat(sat2),
        .chaos_x(x2), .chaos_y(y2), .chaos_z(z2), .chaos_w(w2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step the main core; again_at/rel_at raise step/chaos_reset for edge k after E0 (0 = never)
    task automatic run_main(input logic [4:0] sh, input logic [15:0] it,
                            input int again_at, input int rel_at, output int n);
        int  k;
        bit  fin;
        @(negedge clk);
        shift = sh;
        iters = it;
        step  = 1'b1;
        @(posedge clk); #1;
        busy_err = 0;
        if (busy !== 1'b1 || done !== 1'b0) busy_err++;
        k = 0; n = -1; fin = 0;
        while (!fin && k < 2000) begin
            @(negedge clk);
            k++;
            step   = (k == again_at);
            creset = (k == rel_at);
            @(posedge clk); #1;
            if (k == rel_at) begin
                fin = 1; n = k;
            end else if (done === 1'b1) begin
                fin = 1; n = k;
                if (busy !== 1'b0) busy_err++;
            end else if (busy !== 1'b1) begin
                busy_err++;
            end
        end
        @(negedge clk);
        step   = 1'b0;
        creset = 1'b0;
        $display("run shift=%0d iters=%0d edges=%0d x=%h y=%h z=%h w=%h sat=%b",
                 sh, it, n, x, y, z, w, sat);
    endtask

    task automatic reload();
        @(negedge clk);
        creset = 1'b1;
        @(negedge clk);
        creset = 1'b0;
    endtask

    task automatic run_big();
        @(negedge clk);
        shift = 5'd0;
        iters = 16'd1;
        step2 = 1'b1;
        @(negedge clk);
        step2 = 1'b0;
        for (int k = 0; k < 20 && done2 !== 1'b1; k++) @(negedge clk);
        $display("big run x=%h y=%h z=%h w=%h sat=%b", x2, y2, z2, w2, sat2);
        chk("big_done", {31'd0, done2}, 32'd1);
    endtask

    initial begin
        rstn = 1'b0; creset = 1'b0; step = 1'b0; step2 = 1'b0;
        shift = 5'd0; iters = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", x, 32'h00010000);
        chk("rst_y", y, 32'h0);
        chk("rst_zw", z | w, 32'h0);
        chk("rst_flags", {29'd0, done, busy, sat}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // single iteration, dt = 1/16
        run_main(5'd4, 16'd1, 0, 0, edges);
        chk("i1_edges", edges, 32'd8);
        chk("i1_busy", busy_err, 32'd0);
        chk("i1_x", x, 32'h00006000);
        chk("i1_y", y, 32'h0001C000);
        chk("i1_zw", z | w, 32'h0);
        chk("i1_sat", {31'd0, sat}, 32'd0);

        // iters = 0 behaves as 1
        reload();
        run_main(5'd4, 16'd0, 0, 0, edges);
        chk("i0_edges", edges, 32'd8);
        chk("i0_x", x, 32'h00006000);
        chk("i0_y", y, 32'h0001C000);

        // dt = 1/256
        reload();
        run_main(5'd8, 16'd1, 0, 0, edges);
        chk("s8_x", x, 32'h0000F600);
        chk("s8_y", y, 32'h00001C00);

        // four iterations
        reload();
        run_main(5'd4, 16'd4, 0, 0, edges);
        chk("i4_edges", edges, 32'd32);
        chk("i4_busy", busy_err, 32'd0);
        chk("i4_x", x, 32'h000367CD);
        chk("i4_y", y, 32'h0007568D);
        chk("i4_z", z, 32'h0000B005);
        chk("i4_w", w, 32'hFFFFF002);

        // extra step request mid-run is ignored
        reload();
        run_main(5'd4, 16'd4, 3, 0, edges);
        chk("ign_edges", edges, 32'd32);
        chk("ign_x", x, 32'h000367CD);
        chk("ign_w", w, 32'hFFFFF002);

        // restart straight from DONE
        run_main(5'd4, 16'd1, 0, 0, edges);
        chk("redo_edges", edges, 32'd8);

        // reload at cycle 12 of a 4-iteration run
        reload();
        run_main(5'd4, 16'd4, 0, 12, edges);
        chk("rel_edges", edges, 32'd12);
        chk("rel_x", x, 32'h00010000);
        chk("rel_yzw", y | z | w, 32'h0);
        chk("rel_flags", {30'd0, done, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("rel_idle", {30'd0, done, busy}, 32'd0);
        run_main(5'd4, 16'd1, 0, 0, edges);
        chk("rel2_edges", edges, 32'd8);
        chk("rel2_x", x, 32'h00006000);
        chk("rel2_y", y, 32'h0001C000);

        // reload wins over a simultaneous step
        @(negedge clk);
        creset = 1'b1;
        step   = 1'b1;
        @(posedge clk); #1;
        chk("both_x", x, 32'h00010000);
        chk("both_flags", {30'd0, done, busy}, 32'd0);
        @(negedge clk);
        creset = 1'b0;
        step   = 1'b0;
        @(posedge clk); #1;
        chk("both_idle", {30'd0, done, busy}, 32'd0);

        // saturation on the large-init core
        run_big();
        chk("big_x", x2, 32'h7FFF0000);
        chk("big_y", y2, 32'h7FFFFFFF);
        chk("big_z", z2, 32'h7FFFFFFF);
        chk("big_w", w2, 32'h0);
        chk("big_sat", {31'd0, sat2}, 32'd1);
        chk("main_sat", {31'd0, sat}, 32'd0);
        run_big();
        chk("big_sticky", {31'd0, sat2}, 32'd1);
        reload();
        chk("big_clr", {31'd0, sat2}, 32'd0);
        chk("big_rel_x", x2, 32'h7FFF0000);
        run_big();
        chk("big_sat2", {31'd0, sat2}, 32'd1);

        // hard reset during MUL
        @(negedge clk);
        shift = 5'd4;
        iters = 16'd4;
        step  = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (2) @(negedge clk);
        chk("mul_busy", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("hr_x", x, 32'h00010000);
        chk("hr_yzw", y | z | w, 32'h0);
        chk("hr_flags", {29'd0, done, busy, sat}, 32'd0);
        chk("hr_big_sat", {31'd0, sat2}, 32'd0);
        chk("hr_big_x", x2, 32'h7FFF0000);
        @(negedge clk);
        rstn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
